// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between the requesters and the round-robin arbiter.
interface rr_arbiter8_if;
   logic [7:0] req;
   logic       done;
   logic       sel1;
   logic       sel2;
   logic       sel3;
   logic [7:0] gnt;
   logic       busy;
   logic       timeout;

   modport master (
      output req, done,
      input  sel1, sel2, sel3, gnt, busy, timeout
   );

   modport slave (
      input  req, done,
      output sel1, sel2, sel3, gnt, busy, timeout
   );
endinterface

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters driving the 3-to-8 decoder select lines,
// with release-on-done, hold-limit revocation and a one-cycle turnaround gap.
module rr_arbiter8 #(
   parameter int unsigned MAX_HOLD = 16,
   parameter int unsigned HCW      = 8
) (
   input logic          clk,
   input logic          rst,
   rr_arbiter8_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } state_t;

   state_t           state_q, state_nxt;
   logic [HCW-1:0]   cnt_q, cnt_nxt;
   logic [2:0]       ptr_q, ptr_nxt;
   logic [7:0]       gnt_q, gnt_nxt;
   logic [2:0]       sel_q, sel_nxt;
   logic             busy_q, busy_nxt;
   logic             tmo_q, tmo_nxt;
   logic [2:0]       win;
   logic [2:0]       cand;
   logic             found;

   // Search starts just after the last winner so the last winner is checked last.
   always_comb begin
      win   = ptr_q;
      cand  = ptr_q;
      found = 1'b0;
      for (int i = 1; i < 9; i++) begin
         cand = ptr_q + 3'(i);
         if (!found && bus.req[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   always_comb begin
      state_nxt = state_q;
      cnt_nxt   = cnt_q;
      ptr_nxt   = ptr_q;
      gnt_nxt   = gnt_q;
      sel_nxt   = sel_q;
      busy_nxt  = busy_q;
      tmo_nxt   = 1'b0;
      case (state_q)
         IDLE: begin
            gnt_nxt  = 8'h00;
            sel_nxt  = 3'b000;
            busy_nxt = 1'b0;
            if (|bus.req) begin
               state_nxt = GRANT;
               gnt_nxt   = 8'b1 << win;
               sel_nxt   = win;
               busy_nxt  = 1'b1;
               ptr_nxt   = win;
               cnt_nxt   = HCW'(1);
            end
         end
         GRANT: begin
            // A normal release wins over the hold limit in the same cycle.
            if (bus.done || !bus.req[ptr_q]) begin
               state_nxt = GAP;
               gnt_nxt   = 8'h00;
               sel_nxt   = 3'b000;
               busy_nxt  = 1'b0;
               cnt_nxt   = '0;
            end else if (cnt_q == HCW'(MAX_HOLD)) begin
               state_nxt = GAP;
               gnt_nxt   = 8'h00;
               sel_nxt   = 3'b000;
               busy_nxt  = 1'b0;
               cnt_nxt   = '0;
               tmo_nxt   = 1'b1;
            end else begin
               cnt_nxt = cnt_q + HCW'(1);
            end
         end
         GAP: begin
            state_nxt = IDLE;
            gnt_nxt   = 8'h00;
            sel_nxt   = 3'b000;
            busy_nxt  = 1'b0;
         end
         default: begin
            state_nxt = IDLE;
            gnt_nxt   = 8'h00;
            sel_nxt   = 3'b000;
            busy_nxt  = 1'b0;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ptr_q   <= 3'd7;
         gnt_q   <= 8'h00;
         sel_q   <= 3'b000;
         busy_q  <= 1'b0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_nxt;
         cnt_q   <= cnt_nxt;
         ptr_q   <= ptr_nxt;
         gnt_q   <= gnt_nxt;
         sel_q   <= sel_nxt;
         busy_q  <= busy_nxt;
         tmo_q   <= tmo_nxt;
      end
   end

   assign bus.gnt     = gnt_q;
   assign bus.sel1    = sel_q[2];
   assign bus.sel2    = sel_q[1];
   assign bus.sel3    = sel_q[0];
   assign bus.busy    = busy_q;
   assign bus.timeout = tmo_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8 (MAX_HOLD=4): status word {timeout,busy,sel,gnt}
// is compared against hand-computed values at each negative clock edge.
module tb_rr_arbiter8;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   rr_arbiter8_if bus ();

   rr_arbiter8 #(.MAX_HOLD(4), .HCW(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] st(input logic t, input logic b,
                                      input logic [2:0] s, input logic [7:0] g);
      return {3'b000, t, b, s, g};
   endfunction

   function automatic logic [15:0] obs_st();
      return {3'b000, bus.timeout, bus.busy, bus.sel1, bus.sel2, bus.sel3, bus.gnt};
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      bus.req  = 8'h00;
      bus.done = 1'b0;
      rst      = 1'b1;
      tick();
      rst      = 1'b0;
   endtask

   // Decoder consistency and one-hot invariants while the bench runs.
   always @(negedge clk) begin
      if (!rst && bus.busy) begin
         check("inv_sel", 16'(bus.gnt), 16'(8'b1 << {bus.sel1, bus.sel2, bus.sel3}));
      end
      if (!rst) begin
         check("onehot0", 16'($onehot0(bus.gnt)), 16'd1);
      end
   end

   initial begin
      checks   = 0;
      errors   = 0;
      rst      = 1'b1;
      bus.req  = 8'h00;
      bus.done = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("reset_state", obs_st(), st(0, 0, 3'd0, 8'h00));
      rst = 1'b0;

      // Idle with no requests; stray done must be ignored.
      for (int k = 0; k < 5; k++) begin
         bus.done = (k == 2);
         tick();
         check($sformatf("idle_%0d", k), obs_st(), st(0, 0, 3'd0, 8'h00));
      end
      bus.done = 1'b0;

      // Single requester 2, released by done in its third busy cycle.
      bus.req = 8'h04;
      tick();
      check("r2_busy1", obs_st(), st(0, 1, 3'd2, 8'h04));
      tick();
      check("r2_busy2", obs_st(), st(0, 1, 3'd2, 8'h04));
      tick();
      check("r2_busy3", obs_st(), st(0, 1, 3'd2, 8'h04));
      bus.done = 1'b1;
      tick();
      bus.done = 1'b0;
      check("r2_gap", obs_st(), st(0, 0, 3'd0, 8'h00));
      tick();
      check("r2_idle", obs_st(), st(0, 0, 3'd0, 8'h00));
      tick();
      check("r2_regrant", obs_st(), st(0, 1, 3'd2, 8'h04));
      bus.req = 8'h00;
      tick();
      check("r2_drop_gap", obs_st(), st(0, 0, 3'd0, 8'h00));
      tick();

      // Fairness rotation with all requesting.
      do_reset();
      bus.req = 8'hFF;
      for (int k = 0; k < 9; k++) begin
         tick();
         check($sformatf("rr_grant_%0d", k), obs_st(), st(0, 1, 3'(k % 8), 8'b1 << (k % 8)));
         tick();
         check($sformatf("rr_hold_%0d", k), obs_st(), st(0, 1, 3'(k % 8), 8'b1 << (k % 8)));
         bus.done = 1'b1;
         tick();
         bus.done = 1'b0;
         check($sformatf("rr_gap_%0d", k), obs_st(), st(0, 0, 3'd0, 8'h00));
         tick();
         check($sformatf("rr_idle_%0d", k), obs_st(), st(0, 0, 3'd0, 8'h00));
      end

      // Hold limit: four busy cycles, then a one-cycle timeout pulse.
      do_reset();
      bus.req = 8'h20;
      for (int k = 1; k < 5; k++) begin
         tick();
         check($sformatf("to_busy_%0d", k), obs_st(), st(0, 1, 3'd5, 8'h20));
      end
      tick();
      check("to_pulse", obs_st(), st(1, 0, 3'd0, 8'h00));
      tick();
      check("to_clear", obs_st(), st(0, 0, 3'd0, 8'h00));
      tick();
      check("to_regrant", obs_st(), st(0, 1, 3'd5, 8'h20));
      tick();
      tick();
      tick();
      check("to_busy4_again", obs_st(), st(0, 1, 3'd5, 8'h20));
      bus.done = 1'b1;
      tick();
      bus.done = 1'b0;
      check("to_done_wins", obs_st(), st(0, 0, 3'd0, 8'h00));
      bus.req = 8'h00;
      tick();
      tick();

      // Owner 3 drops request; 1 and 6 pending, search from 4 picks 6.
      do_reset();
      bus.req = 8'h08;
      tick();
      check("r3_grant", obs_st(), st(0, 1, 3'd3, 8'h08));
      bus.req = 8'h4A;
      tick();
      check("r3_no_preempt", obs_st(), st(0, 1, 3'd3, 8'h08));
      bus.req = 8'h42;
      tick();
      check("r3_drop_gap", obs_st(), st(0, 0, 3'd0, 8'h00));
      tick();
      check("r3_idle", obs_st(), st(0, 0, 3'd0, 8'h00));
      tick();
      check("r6_grant", obs_st(), st(0, 1, 3'd6, 8'h40));
      bus.req = 8'h00;
      tick();
      tick();

      // Reset in the second busy cycle; pointer back to 7.
      bus.req = 8'h10;
      tick();
      check("r4_grant", obs_st(), st(0, 1, 3'd4, 8'h10));
      tick();
      check("r4_busy2", obs_st(), st(0, 1, 3'd4, 8'h10));
      rst = 1'b1;
      tick();
      check("mid_reset", obs_st(), st(0, 0, 3'd0, 8'h00));
      rst     = 1'b0;
      bus.req = 8'h81;
      tick();
      check("post_reset_r0", obs_st(), st(0, 1, 3'd0, 8'h01));
      bus.req = 8'h00;
      tick();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- Round-robin arbiter and sequencer that shares the 3-to-8 decoded resource among 8 requesters.
- Selects one requester and drives the decoder select lines {sel1,sel2,sel3} with its index.
- Keeps the grant until the owner releases it or a hold timeout expires.
- Sits directly in front of encode3to8; its registered one-hot gnt must always equal the decoder output while busy.

Parameters:
- MAX_HOLD, 16: maximum grant length in cycles; legal range 1..255.
- HCW, 8: hold counter width; must satisfy 2^HCW > MAX_HOLD.

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  8  request vector; bit i = requester i; level-sensitive.
- done  in  1  release pulse from the current owner; sampled only in GRANT.
- sel1  out  1  grant index bit 2 (MSB) to decoder.
- sel2  out  1  grant index bit 1.
- sel3  out  1  grant index bit 0 (LSB).
- gnt  out  8  registered one-hot grant; all zeros when no grant.
- busy  out  1  high while in GRANT.
- timeout  out  1  one-cycle pulse when a grant is revoked by the hold limit.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values:
  - gnt=0, {sel1,sel2,sel3}=000, busy=0, timeout=0.
  - State=IDLE, hold counter=0, last-winner pointer=7, so requester 0 has first priority.
- Reset asserted mid-grant: the grant is dropped on the next edge, with no GAP cycle and no timeout pulse.
- States are IDLE, GRANT, GAP.
- IDLE:
  - If req≠0 at edge N, pick the winner by searching last+1, last+2, ... wrapping mod 8; the last winner is checked last.
  - At edge N, gnt is set to the one-hot winner, {sel1,sel2,sel3} to the winner index, busy=1, pointer to the winner, counter=1. Grant latency is 1 cycle.
  - If req=0, stay in IDLE with outputs zero.
- GRANT, release conditions evaluated each edge:
  - (a) done=1, or (b) req[owner]=0: go to GAP; gnt=0, sel=000, busy=0, timeout=0.
  - (c) Otherwise, if counter==MAX_HOLD: go to GAP with timeout=1 for exactly that one cycle.
  - Otherwise: counter+1, outputs held.
- GRANT precedence and masking:
  - done and the limit in the same cycle counts as a normal release; timeout stays 0.
  - Changes on the req bits of other requesters have no effect during GRANT; no preemption.
- Grant lifetime:
  - A grant lasts at most MAX_HOLD cycles of busy=1.
  - MAX_HOLD=1 gives single-cycle grants.
- GAP:
  - Always exactly 1 cycle, gnt=0, then IDLE.
  - Guarantees a dead cycle between owners for decoder and bus turnaround.
  - Back-to-back ownership therefore costs 2 cycles of gnt=0: GAP plus IDLE arbitration.
- done outside GRANT is ignored. sel and gnt never change except at these transitions.
- Fairness: with all 8 requesting continuously, owners rotate 0,1,...,7,0; every requester is served within 8 grants.
- Invariants:
  - gnt is one-hot or zero.
  - When busy=1, gnt == (1 << {sel1,sel2,sel3}).
  - busy=1 iff state=GRANT.

Test Plan:
- Reset, then req=8'h00 for 5 cycles -> gnt=00, sel=000, busy=0, timeout=0 throughout.
- req=8'b0000_0100 held, done pulsed at the 3rd busy cycle -> gnt=04 and sel=010 one cycle after req, busy for 3 cycles, then one GAP cycle, then regranted to 2 after the IDLE cycle.
- req=8'hFF held, done pulsed every 2nd busy cycle -> owner sequence 0,1,2,...,7,0 with sel=000,001,...,111,000 and a 2-cycle zero-gnt gap between grants.
- MAX_HOLD=4, req=8'h20 held, done never -> gnt=20 (sel=101) for exactly 4 cycles, then timeout=1 for one cycle with gnt=00; done and limit coincident in a second run -> timeout stays 0.
- req[3] granted, req[3] dropped while req[6]=1 -> release next edge, GAP, then gnt=40 (sel=110); with req[1] and req[6] both pending after owner 3, the search order gives 6 first.
- rst asserted during the 2nd busy cycle of a grant -> next edge gnt=00, busy=0, pointer=7; with req=8'h81 after reset, requester 0 wins first.
